i2s_frame_ctrl: RTL and testbench
=================================

Name: i2s_frame_ctrl

Overview:
Master-mode I2S timing and sample scheduler for the audio path.
- Generates sclk and lrclk from the system clock.
- Accepts stereo samples from the mixer/sound-effect logic through a valid/ready handshake and holds one pending sample pair.
- Presents data_l/data_r to the downstream I2S serializer at a fixed commit point in each frame.
- Reports underruns and handles start and stop on frame boundaries.

Parameters:
CLK_DIV, 2, clk cycles per sclk half-period (>=1); sclk period = 2*CLK_DIV clk
BITS_PER_CH, 32, sclk periods per channel half-frame; frame = 2*BITS_PER_CH sclk periods
UCNT_W, 16, width of saturating underrun counter

Ports:
clk  in  1  system clock; all logic on posedge clk
reset  in  1  synchronous, active-high reset
enable  in  1  run request; level-sensitive
s_valid  in  1  upstream sample pair valid
s_left  in  32  upstream left sample
s_right  in  32  upstream right sample
s_ready  out  1  holding buffer empty; transfer when s_valid&&s_ready
sclk  out  1  I2S bit clock (registered)
lrclk  out  1  I2S word select, 0=left, 1=right (registered)
data_l  out  32  left word to serializer
data_r  out  32  right word to serializer
frame_start  out  1  one-clk pulse at commit point
underrun  out  1  one-clk pulse when commit finds buffer empty in RUN
underrun_count  out  UCNT_W  saturating underrun total
running  out  1  state != IDLE

Behaviour:
Clock port is clk; reset port is reset. One clock; reset is synchronous and active-high.

Reset (sync, active-high):
- Outputs: sclk=0, lrclk=0, data_l=0, data_r=0, frame_start=0, underrun=0, underrun_count=0, state=IDLE.
- Buffer is empty; s_ready=0 during reset and 1 on the first cycle after.
- Reset mid-frame aborts immediately; no completion of the frame.

Holding buffer (one entry):
- s_ready = !buf_full && !reset.
- Accept on s_valid&&s_ready; buf_full sets the next cycle.
- Accepting is allowed in any state, including IDLE prefill.
- Accept and consume in the same cycle is impossible because s_ready=0 when full.
- s_valid held while s_ready=0 has no effect.

Divider:
- div_cnt counts 0..CLK_DIV-1 while running; at CLK_DIV-1 it wraps and sclk toggles.
- fall_tick marks the cycle sclk goes 1->0.
- bit_cnt advances on each fall_tick, counting 0..BITS_PER_CH-1 and wrapping.
- lrclk toggles on the fall_tick where bit_cnt==BITS_PER_CH-1 (wraps to 0).

Commit point:
- The clk cycle on which lrclk goes 0->1 (start of the right half).
- frame_start pulses that cycle; data_l/data_r update on the same edge.
- The serializer loads data_l during the right half and data_r during the next left half, so a committed pair plays as the next full frame.
- Latency from commit to left MSB on the wire is one half-frame.

FSM:
- IDLE:
  - sclk=0, lrclk=0, div_cnt=0, bit_cnt=0.
  - enable=1 -> RUN on the next cycle.
  - The first sclk rise occurs CLK_DIV cycles after entering RUN.
- RUN, at a commit:
  - buf_full: data_l<=buffer L, data_r<=buffer R, buffer emptied.
  - empty: data_l/data_r<=0, underrun pulse, underrun_count+1, saturating at all-ones.
- RUN, enable=0 -> DRAIN on the next cycle.
- DRAIN:
  - Timing continues.
  - A commit in DRAIN loads zeros, does not consume the buffer and raises no underrun; frame_start still pulses.
  - On the cycle lrclk goes 1->0 (end of frame) -> IDLE, with sclk forced 0 and lrclk 0.
- enable re-asserted during DRAIN is ignored until IDLE is reached; it then re-enters RUN the next cycle.

Decomposition:
- Package i2s_pkg:
  - state enum {IDLE, RUN, DRAIN}
  - AUDIO_W=32, default CLK_DIV and BITS_PER_CH constants
- Sub-module i2s_clk_div:
  - Holds div_cnt, bit_cnt, sclk and lrclk registers.
  - Exposes fall_tick, lr_rise and lr_fall pulses plus a run input that synchronously clears it.
- The top holds the FSM, buffer and counters.

Test Plan:
1. Timing (CLK_DIV=2, BITS_PER_CH=32): reset, enable=1 -> sclk period 4 clk, lrclk period 256 clk; first lrclk rise 128 clk after RUN entry; frame_start once per 256 clk.
2. Handshake/commit: push L=0x12345678, R=0x9ABCDEF0 in IDLE (s_ready drops next cycle) -> at first commit data_l/data_r take those values, s_ready returns to 1 the next cycle, no underrun.
3. Underrun: run 3 frames with no s_valid -> 3 underrun pulses, underrun_count=3, data_l=data_r=0; with UCNT_W=2 and 5 frames -> count stays 3.
4. Stop: deassert enable mid-left-half with a sample buffered -> one more commit of zeros, buffer still full, IDLE on the next lrclk fall, sclk=lrclk=0, running=0.
5. Reset mid-frame: assert reset 1 cycle during the right half -> next cycle all outputs at reset values, buffer empty, s_ready=1.
6. Back-pressure: hold s_valid=1 with a changing payload -> exactly one accept per frame, each committed value equals the payload present on its accept cycle.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S frame controller.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int AUDIO_W         = 32;
  localparam int DEF_CLK_DIV     = 2;
  localparam int DEF_BITS_PER_CH = 32;

endpackage

// File: rtl/i2s_clk_div.sv
// I2S bit/word clock generator; held cleared while run is low.
module i2s_clk_div
  import i2s_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int BITS_PER_CH = DEF_BITS_PER_CH
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic sclk,
  output logic lrclk,
  output logic fall_tick,
  output logic lr_rise,
  output logic lr_fall
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (BITS_PER_CH > 1) ? $clog2(BITS_PER_CH) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(BITS_PER_CH - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             div_wrap;
  logic             bit_last;

  // Tick decode: pulses mark the cycle whose closing edge moves the clocks.
  always_comb begin
    div_wrap  = (div_cnt == DIV_MAX);
    bit_last  = (bit_cnt == BIT_MAX);
    fall_tick = run && div_wrap && sclk;
    lr_rise   = fall_tick && bit_last && !lrclk;
    lr_fall   = fall_tick && bit_last && lrclk;
  end

  // Divider, bit counter and clock registers; the last lrclk fall wraps everything to zero.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      lrclk   <= 1'b0;
    end else begin
      if (div_wrap) begin
        div_cnt <= '0;
        sclk    <= !sclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (fall_tick) begin
        if (bit_last) begin
          bit_cnt <= '0;
          lrclk   <= !lrclk;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/i2s_frame_ctrl.sv
// Master-mode I2S frame controller: clocking, one-entry sample buffer,
// commit of sample pairs at the lrclk rise, underrun accounting and start/stop.
module i2s_frame_ctrl
  import i2s_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int BITS_PER_CH = DEF_BITS_PER_CH,
  parameter int UCNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               s_valid,
  input  logic [AUDIO_W-1:0] s_left,
  input  logic [AUDIO_W-1:0] s_right,
  output logic               s_ready,
  output logic               sclk,
  output logic               lrclk,
  output logic [AUDIO_W-1:0] data_l,
  output logic [AUDIO_W-1:0] data_r,
  output logic               frame_start,
  output logic               underrun,
  output logic [UCNT_W-1:0]  underrun_count,
  output logic               running
);

  state_t             state;
  state_t             state_next;
  logic               buf_full;
  logic [AUDIO_W-1:0] buf_l;
  logic [AUDIO_W-1:0] buf_r;
  logic               fall_tick;
  logic               lr_rise;
  logic               lr_fall;
  logic               accept;
  logic               commit;
  logic               take;
  logic               starve;

  i2s_clk_div #(
    .CLK_DIV    (CLK_DIV),
    .BITS_PER_CH(BITS_PER_CH)
  ) u_clk_div (
    .clk      (clk),
    .reset    (reset),
    .run      (running),
    .sclk     (sclk),
    .lrclk    (lrclk),
    .fall_tick(fall_tick),
    .lr_rise  (lr_rise),
    .lr_fall  (lr_fall)
  );

  // Handshake and commit decode; only RUN consumes the buffer or counts starvation.
  always_comb begin
    s_ready = !buf_full && !reset;
    running = (state != IDLE);
    accept  = s_valid && s_ready;
    commit  = fall_tick && lr_rise;
    take    = commit && (state == RUN) && buf_full;
    starve  = commit && (state == RUN) && !buf_full;
  end

  // Next-state logic: stopping always completes the current frame via DRAIN.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (enable) state_next = RUN;
        else        state_next = IDLE;
      end
      RUN: begin
        if (!enable) state_next = DRAIN;
        else         state_next = RUN;
      end
      DRAIN: begin
        if (fall_tick && lr_fall) state_next = IDLE;
        else                      state_next = DRAIN;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // One-entry holding buffer; accept and take are mutually exclusive.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_full <= 1'b0;
      buf_l    <= '0;
      buf_r    <= '0;
    end else if (accept) begin
      buf_full <= 1'b1;
      buf_l    <= s_left;
      buf_r    <= s_right;
    end else if (take) begin
      buf_full <= 1'b0;
    end
  end

  // Commit outputs and saturating underrun counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_l         <= '0;
      data_r         <= '0;
      frame_start    <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      frame_start <= commit;
      underrun    <= starve;
      if (commit) begin
        data_l <= take ? buf_l : '0;
        data_r <= take ? buf_r : '0;
      end
      if (starve && (underrun_count != {UCNT_W{1'b1}})) begin
        underrun_count <= underrun_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Scoreboard bench for i2s_frame_ctrl against a cycle-count based reference model.
module tb_i2s_frame_ctrl;

  localparam int CLK_DIV = 2;
  localparam int BITS    = 32;
  localparam int UCNT_W  = 2;
  localparam int HALF    = 2 * CLK_DIV * BITS;
  localparam int FRAME   = 2 * HALF;
  localparam int UMAX    = (1 << UCNT_W) - 1;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  typedef struct packed {
    logic [31:0] l;
    logic [31:0] r;
    logic        ur;
    logic [31:0] cnt;
  } commit_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_left = 32'd0;
  logic [31:0] s_right = 32'd0;
  logic        s_ready, sclk, lrclk, frame_start, underrun, running;
  logic [31:0] data_l, data_r;
  logic [UCNT_W-1:0] underrun_count;

  i2s_frame_ctrl #(
    .CLK_DIV(CLK_DIV), .BITS_PER_CH(BITS), .UCNT_W(UCNT_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .s_valid(s_valid),
    .s_left(s_left), .s_right(s_right), .s_ready(s_ready), .sclk(sclk),
    .lrclk(lrclk), .data_l(data_l), .data_r(data_r), .frame_start(frame_start),
    .underrun(underrun), .underrun_count(underrun_count), .running(running)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: position in the frame is just cycles since RUN entry.
  int          m_state = M_IDLE;
  int          m_cnt = 0;
  int          m_ucnt = 0;
  bit          m_full = 1'b0;
  bit          m_fs = 1'b0;
  bit          m_ur = 1'b0;
  logic [31:0] m_bl = 32'd0, m_br = 32'd0, m_dl = 32'd0, m_dr = 32'd0;
  commit_t     exp_q[$];

  always @(posedge clk) begin
    commit_t c;
    bit acc;
    acc  = s_valid && !m_full && !reset;
    m_fs = 1'b0;
    m_ur = 1'b0;
    if (reset) begin
      m_state = M_IDLE; m_cnt = 0; m_full = 1'b0; m_ucnt = 0;
      m_dl = 32'd0; m_dr = 32'd0;
      exp_q.delete();
    end else begin
      if (m_state == M_IDLE) begin
        if (enable) begin m_state = M_RUN; m_cnt = 0; end
      end else begin
        m_cnt++;
        if (m_cnt % FRAME == HALF) begin
          m_fs = 1'b1;
          if (m_state == M_RUN && m_full) begin
            m_dl = m_bl; m_dr = m_br; m_full = 1'b0;
          end else begin
            m_dl = 32'd0; m_dr = 32'd0;
            if (m_state == M_RUN) begin
              m_ur = 1'b1;
              if (m_ucnt < UMAX) m_ucnt++;
            end
          end
          c.l = m_dl; c.r = m_dr; c.ur = m_ur; c.cnt = m_ucnt;
          exp_q.push_back(c);
        end
        if (m_state == M_DRAIN && m_cnt % FRAME == 0) m_state = M_IDLE;
        else if (m_state == M_RUN && !enable) m_state = M_DRAIN;
      end
      if (acc) begin m_full = 1'b1; m_bl = s_left; m_br = s_right; end
    end
  end

  // Monitor: per-cycle control check plus scoreboard pop on every frame_start.
  always @(negedge clk) begin
    if (chk_en) begin
      commit_t c;
      bit run_e;
      logic [5:0] exp_v, got_v;
      run_e = (m_state != M_IDLE);
      exp_v = {run_e && ((m_cnt / CLK_DIV) % 2 == 1), run_e && ((m_cnt / HALF) % 2 == 1),
               run_e, !m_full && !reset, m_fs, m_ur};
      got_v = {sclk, lrclk, running, s_ready, frame_start, underrun};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL ctrl t=%0t sclk/lrclk/running/s_ready/frame_start/underrun got %b expected %b",
                 $time, got_v, exp_v);
      end
      if (frame_start) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL commit_unexpected t=%0t got frame_start=1 expected no commit", $time);
        end else begin
          c = exp_q.pop_front();
          if ({data_l, data_r, underrun, underrun_count} !== {c.l, c.r, c.ur, c.cnt[UCNT_W-1:0]}) begin
            errors++;
            $display("FAIL commit t=%0t got L=%h R=%h ur=%b cnt=%0d expected L=%h R=%h ur=%b cnt=%0d",
                     $time, data_l, data_r, underrun, underrun_count, c.l, c.r, c.ur, c.cnt);
          end
        end
      end else if (exp_q.size() != 0) begin
        c = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL commit_missing t=%0t got frame_start=0 expected commit L=%h R=%h", $time, c.l, c.r);
      end
      checks++;
      if ({data_l, data_r, underrun_count} !== {m_dl, m_dr, m_ucnt[UCNT_W-1:0]}) begin
        errors++;
        $display("FAIL hold t=%0t got L=%h R=%h cnt=%0d expected L=%h R=%h cnt=%0d",
                 $time, data_l, data_r, underrun_count, m_dl, m_dr, m_ucnt);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic timeout(input string what);
    checks++;
    errors++;
    $display("FAIL %s got timeout expected condition within budget", what);
  endtask

  initial begin
    bit ok;
    // Reset, then prefill one pair while IDLE.
    reset = 1'b1;
    step();
    chk_en = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    s_valid = 1'b1; s_left = 32'h12345678; s_right = 32'h9ABCDEF0;
    step();
    s_valid = 1'b0; s_left = 32'hDEADBEEF; s_right = 32'hCAFEF00D;
    step(); step();

    // Run six frames: the prefilled pair commits, then underruns saturate the counter.
    enable = 1'b1;
    repeat (6 * FRAME) step();

    // Back-pressure with a payload that changes every cycle.
    repeat (5 * FRAME) begin
      s_valid = 1'b1; s_left = $urandom; s_right = $urandom;
      step();
    end

    // Stop mid-left-half with a pair buffered.
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME && !ok; i++) begin
      if (m_full && m_state == M_RUN && m_cnt % FRAME == 40) ok = 1'b1;
      else begin s_left = $urandom; s_right = $urandom; step(); end
    end
    if (!ok) timeout("stop_setup");
    s_valid = 1'b0;
    enable = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME && !ok; i++) begin
      step();
      if (m_state == M_IDLE) ok = 1'b1;
    end
    if (!ok) timeout("stop_idle");
    checks++;
    if ({running, sclk, lrclk, s_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL stop_idle got running/sclk/lrclk/s_ready=%b expected 0000",
               {running, sclk, lrclk, s_ready});
    end
    repeat (10) step();

    // Restart (buffered pair commits), then reset for one cycle in the right half.
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 3 * FRAME && !ok; i++) begin
      step();
      if (m_state == M_RUN && m_cnt > FRAME && m_cnt % FRAME == 200) ok = 1'b1;
    end
    if (!ok) timeout("reset_setup");
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    checks++;
    if ({s_ready, data_l, data_r} !== {1'b1, 64'd0}) begin
      errors++;
      $display("FAIL reset_mid got s_ready=%b L=%h R=%h expected s_ready=1 L=0 R=0",
               s_ready, data_l, data_r);
    end

    // Randomised traffic with occasional enable toggles.
    repeat (24 * FRAME) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_left = $urandom;
      s_right = $urandom;
      if ($urandom_range(0, 499) == 0) enable = !enable;
      step();
    end

    s_valid = 1'b0;
    enable = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3 * FRAME && !ok; i++) begin
      step();
      if (m_state == M_IDLE) ok = 1'b1;
    end
    if (!ok) timeout("final_idle");
    repeat (4) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_empty got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
